// File: rtl/cache_mem_responder_pkg.sv
// Shared cache package: block geometry, block data type, responder states.
// Also provides the reset-pattern helper used by the backing store.
package cache_mem_responder_pkg;

    localparam int CACHE_DATA_BITS  = 32;
    localparam int CACHE_BLOCK_BITS = 2;
    localparam int BLOCK_SIZE       = 2 ** CACHE_BLOCK_BITS;

    typedef logic [BLOCK_SIZE-1:0][CACHE_DATA_BITS-1:0] block_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE_WAIT,
        READ_WAIT,
        RESP,
        HOLDOFF
    } state_t;

    // Reset value of word `off` in block `blk`: the concatenation {blk,off}.
    function automatic int unsigned reset_word(
        input int unsigned blk,
        input int unsigned off,
        input int unsigned block_bits
    );
        return (blk << block_bits) | off;
    endfunction

endpackage

// File: rtl/cache_mem_responder_block_mem.sv
// Block-wide backing store: one registered read port, one write port.
// Ports: clk, reset, rd_en/rd_addr/rd_data, wr_en/wr_addr/wr_data.
module block_mem
    import cache_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 32,
    parameter int BLOCK_BITS = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   rd_en,
    input  logic [ADDR_BITS-1:0]                   rd_addr,
    output logic [2**BLOCK_BITS-1:0][DATA_BITS-1:0] rd_data,
    input  logic                                   wr_en,
    input  logic [ADDR_BITS-1:0]                   wr_addr,
    input  logic [2**BLOCK_BITS-1:0][DATA_BITS-1:0] wr_data
);

    localparam int WORDS      = 2 ** BLOCK_BITS;
    localparam int NUM_BLOCKS = 2 ** ADDR_BITS;

    logic [WORDS-1:0][DATA_BITS-1:0] mem [NUM_BLOCKS];

    // The read register doubles as the response bus: it holds zero
    // in every cycle that does not follow a read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                for (int o = 0; o < WORDS; o++) begin
                    mem[ADDR_BITS'(b)][BLOCK_BITS'(o)] <=
                        DATA_BITS'(reset_word(b, o, BLOCK_BITS));
                end
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= rd_en ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Fixed-latency block memory responder for the cache refill/writeback path.
// Ports: clk, reset, prop_address/read_en/write_en/write_data in; ram_valid, ram_data, busy out.
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int LATENCY          = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [RAM_ADDRESS_BITS-1:0]            prop_address,
    input  logic                                   prop_read_en,
    input  logic [2**BLOCK_BITS-1:0][DATA_BITS-1:0] prop_write_data,
    input  logic                                   prop_write_en,
    output logic                                   ram_valid,
    output logic [2**BLOCK_BITS-1:0][DATA_BITS-1:0] ram_data,
    output logic                                   busy
);

    localparam int WORDS = 2 ** BLOCK_BITS;
    localparam int BA_W  = RAM_ADDRESS_BITS - BLOCK_BITS;

    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);
    // A read queued behind a write counts its latency from the write's
    // response edge, so the pair completes at 2*LATENCY after acceptance.
    localparam logic [3:0] PEND_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t                          state;
    logic [3:0]                      cnt;
    logic                            pend_rd;
    logic [BA_W-1:0]                 blk_q;
    logic [WORDS-1:0][DATA_BITS-1:0] wdata_q;

    logic wait_done;
    logic mem_wr;
    logic mem_rd;
    logic unused_offset;

    assign unused_offset = ^prop_address[BLOCK_BITS-1:0];

    assign wait_done = (cnt == 4'd0);
    assign mem_wr    = (state == WRITE_WAIT) && wait_done;
    assign mem_rd    = (state == READ_WAIT) && wait_done;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pend_rd   <= 1'b0;
            ram_valid <= 1'b0;
            blk_q     <= '0;
            wdata_q   <= '0;
        end else begin
            ram_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (prop_write_en) begin
                        blk_q   <= prop_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
                        wdata_q <= prop_write_data;
                        pend_rd <= prop_read_en;
                        cnt     <= WAIT_LOAD;
                        state   <= WRITE_WAIT;
                    end else if (prop_read_en) begin
                        blk_q <= prop_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
                        cnt   <= WAIT_LOAD;
                        state <= READ_WAIT;
                    end
                end
                WRITE_WAIT, READ_WAIT: begin
                    if (wait_done) begin
                        ram_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (pend_rd) begin
                        pend_rd <= 1'b0;
                        cnt     <= PEND_LOAD;
                        state   <= READ_WAIT;
                    end else begin
                        cnt   <= 4'd1;
                        state <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (wait_done) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    block_mem #(
        .ADDR_BITS (BA_W),
        .DATA_BITS (DATA_BITS),
        .BLOCK_BITS(BLOCK_BITS)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .rd_en  (mem_rd),
        .rd_addr(blk_q),
        .rd_data(ram_data),
        .wr_en  (mem_wr),
        .wr_addr(blk_q),
        .wr_data(wdata_q)
    );

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized bench for cache_mem_responder against a transaction-level model.
// Model: accepted requests become scheduled completions on an edge timeline.
module tb_cache_mem_responder;
    import cache_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  prop_address;
    logic        prop_read_en;
    block_t      prop_write_data;
    logic        prop_write_en;
    logic        ram_valid;
    block_t      ram_data;
    logic        busy;

    cache_mem_responder #(
        .RAM_ADDRESS_BITS(10),
        .DATA_BITS       (32),
        .BLOCK_BITS      (2),
        .LATENCY         (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .prop_address   (prop_address),
        .prop_read_en   (prop_read_en),
        .prop_write_data(prop_write_data),
        .prop_write_en  (prop_write_en),
        .ram_valid      (ram_valid),
        .ram_data       (ram_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        bit         wr;
        logic [7:0] blk;
        block_t     data;
    } ev_t;

    ev_t    evq[$];
    block_t mmem [256];
    int     edge_n;
    int     free_at;
    int     last_acc;
    int     pulse_edge;
    int     n_pulse;
    block_t last_rd;
    int     n_chk;
    int     n_bad;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 256; b++)
            for (int o = 0; o < 4; o++)
                mmem[b][o] = 32'(b * 4 + o);
        evq.delete();
        edge_n  = 0;
        free_at = 1;
    endtask

    // Drive one request set for the next edge, then check the cycle after it.
    task automatic cycle(input bit we, input bit re, input logic [9:0] a,
                         input block_t d);
        int     e;
        ev_t    ev;
        logic   exp_v;
        block_t exp_d;
        prop_write_en   = we;
        prop_read_en    = re;
        prop_address    = a;
        prop_write_data = d;
        e = edge_n + 1;
        if (e >= free_at && (we || re)) begin
            last_acc = e;
            if (we) begin
                evq.push_back('{at: e + 4, wr: 1'b1, blk: a[9:2], data: d});
                if (re) begin
                    evq.push_back('{at: e + 8, wr: 1'b0, blk: a[9:2], data: '0});
                    free_at = e + 12;
                end else begin
                    free_at = e + 8;
                end
            end else begin
                evq.push_back('{at: e + 4, wr: 1'b0, blk: a[9:2], data: '0});
                free_at = e + 8;
            end
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        exp_v = 1'b0;
        exp_d = '0;
        if (evq.size() > 0 && evq[0].at == edge_n) begin
            ev = evq.pop_front();
            exp_v = 1'b1;
            if (ev.wr) mmem[ev.blk] = ev.data;
            else exp_d = mmem[ev.blk];
        end
        if (ram_valid === 1'b1) begin
            n_pulse++;
            pulse_edge = edge_n;
            last_rd = ram_data;
        end
        chk("valid", ram_valid, exp_v);
        chk("data", ram_data, exp_d);
        chk("busy", busy, edge_n < free_at - 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 10'h000, '0);
    endtask

    function automatic block_t rnd_blk();
        block_t r;
        for (int o = 0; o < 4; o++) r[o] = $urandom;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=%0d", edge_n, 0);
        $fatal(1, "timeout");
    end

    initial begin
        block_t wd;
        int     p0;
        n_chk = 0;
        n_bad = 0;
        n_pulse = 0;
        pulse_edge = 0;
        last_acc = 0;
        last_rd = '0;
        reset = 1'b1;
        prop_write_en = 1'b0;
        prop_read_en = 1'b0;
        prop_address = '0;
        prop_write_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", ram_valid, 1'b0);
        chk("rst_data", ram_data, 128'h0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;

        // Refill read of a reset-pattern block
        cycle(1'b0, 1'b1, 10'h013, '0);
        idle(8);
        chk("rd_lat", 32'(pulse_edge - last_acc), 32'd4);
        chk("rd_w0", last_rd[0], 32'h010);
        chk("rd_w3", last_rd[3], 32'h013);

        // Writeback then readback through a different offset
        wd = rnd_blk();
        cycle(1'b1, 1'b0, 10'h020, wd);
        idle(7);
        chk("wb_lat", 32'(pulse_edge - last_acc), 32'd4);
        cycle(1'b0, 1'b1, 10'h022, '0);
        idle(8);
        chk("wb_readback", last_rd, wd);

        // Both enables: write first, queued read sees the new block
        wd = rnd_blk();
        cycle(1'b1, 1'b1, 10'h040, wd);
        idle(12);
        chk("both_lat", 32'(pulse_edge - last_acc), 32'd8);
        chk("both_data", last_rd, wd);

        // Top of the address space
        cycle(1'b0, 1'b1, 10'h3FF, '0);
        idle(8);
        chk("top_w3", last_rd[3], 32'h3FF);
        chk("top_w0", last_rd[0], 32'h3FC);

        // Read held high: one completion per full request cycle
        // (IDLE acceptance cycle + 4 latency + 1 RESP + 2 HOLDOFF = 8)
        p0 = n_pulse;
        for (int i = 0; i < 24; i++) cycle(1'b0, 1'b1, 10'h100, '0);
        idle(8);
        chk("held_pulses", 32'(n_pulse - p0), 32'd3);

        // Random traffic, including requests while busy
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 3) == 0,
                  10'($urandom), rnd_blk());
        end
        idle(12);

        // Reset in the middle of a writeback aborts it
        wd = rnd_blk();
        p0 = n_pulse;
        cycle(1'b1, 1'b0, 10'h2A5, wd);
        idle(2);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", ram_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_data", ram_data, 128'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        chk("mid_rst_nopulse", 32'(n_pulse - p0), 32'd0);
        cycle(1'b0, 1'b1, 10'h2A4, '0);
        idle(8);
        chk("mid_rst_w0", last_rd[0], 32'h2A4);
        chk("mid_rst_w2", last_rd[2], 32'h2A6);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
